// File: rtl/time_set_ctrl.sv
// Time-setting controller: turns MODE/ADV buttons into digit load strobes
// for the HH:MM registers, with auto-repeat and an idle return to RUN.
module time_set_ctrl #(
    parameter logic [15:0] REPEAT_DELAY = 16'd50000,
    parameter logic [15:0] REPEAT_RATE  = 16'd12500,
    parameter logic [23:0] IDLE_TIMEOUT = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_adv,
    input  logic [3:0] hr_t,
    input  logic [3:0] hr_o,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    output logic [3:0] new_val,
    output logic       set_hr_t,
    output logic       set_hr_o,
    output logic       set_min_t,
    output logic       set_min_o,
    output logic       run_en,
    output logic [3:0] edit_sel
);

    typedef enum logic [2:0] {RUN, E_HT, E_HO, E_MT, E_MO} state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  mode_sync;
    logic [1:0]  adv_sync;
    logic        mode_prev;
    logic        adv_prev;
    logic        mode_edge;
    logic        adv_edge;
    logic        adv_lvl;
    logic        in_edit;
    logic [15:0] rpt_cnt;
    logic        rpt_phase;
    logic        rpt_tick;
    logic        adv_evt;
    logic [23:0] idle_cnt;
    logic        idle_expired;
    logic [3:0]  nxt_digit;
    logic [3:0]  set_n;
    logic [3:0]  val_n;
    logic        run_en_n;
    logic [3:0]  sel_n;

    // Two-flop synchronisers plus previous-level flops for rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_sync <= 2'b00;
            adv_sync  <= 2'b00;
            mode_prev <= 1'b0;
            adv_prev  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            adv_sync  <= {adv_sync[0], btn_adv};
            mode_prev <= mode_sync[1];
            adv_prev  <= adv_sync[1];
        end
    end

    assign mode_edge    = mode_sync[1] & ~mode_prev;
    assign adv_lvl      = adv_sync[1];
    assign adv_edge     = adv_lvl & ~adv_prev;
    assign in_edit      = (state != RUN);
    assign rpt_tick     = in_edit & adv_lvl &
                          (rpt_phase ? (rpt_cnt == REPEAT_RATE) : (rpt_cnt == REPEAT_DELAY));
    assign adv_evt      = in_edit & ~mode_edge & (adv_edge | rpt_tick);
    assign idle_expired = in_edit & (idle_cnt == IDLE_TIMEOUT - 24'd1);

    // Held-ADV counter: first tick after REPEAT_DELAY, then every REPEAT_RATE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= 16'd0;
            rpt_phase <= 1'b0;
        end else if (!in_edit || !adv_lvl || (state_n != state)) begin
            rpt_cnt   <= 16'd0;
            rpt_phase <= 1'b0;
        end else if (rpt_tick) begin
            rpt_cnt   <= 16'd1;
            rpt_phase <= 1'b1;
        end else if (rpt_cnt != 16'hFFFF) begin
            rpt_cnt   <= rpt_cnt + 16'd1;
        end
    end

    // Idle counter: restarts on any button activity while editing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= 24'd0;
        end else if (!in_edit || mode_edge || adv_edge || rpt_tick) begin
            idle_cnt <= 24'd0;
        end else if (idle_cnt != 24'hFFFFFF) begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Next state: MODE steps through the digits; idle falls back to RUN
    always_comb begin
        state_n = state;
        if (mode_edge) begin
            case (state)
                RUN:     state_n = E_HT;
                E_HT:    state_n = E_HO;
                E_HO:    state_n = E_MT;
                E_MT:    state_n = E_MO;
                default: state_n = RUN;
            endcase
        end else if (!adv_edge && !rpt_tick && idle_expired) begin
            state_n = RUN;
        end
    end

    // Next legal BCD value for the digit under edit
    always_comb begin
        nxt_digit = 4'd0;
        case (state)
            E_HT: nxt_digit = (hr_t >= 4'd2) ? 4'd0 : hr_t + 4'd1;
            E_HO: begin
                if (hr_t >= 4'd2) begin
                    nxt_digit = (hr_o >= 4'd3) ? 4'd0 : hr_o + 4'd1;
                end else begin
                    nxt_digit = (hr_o >= 4'd9) ? 4'd0 : hr_o + 4'd1;
                end
            end
            E_MT:    nxt_digit = (min_t >= 4'd5) ? 4'd0 : min_t + 4'd1;
            E_MO:    nxt_digit = (min_o >= 4'd9) ? 4'd0 : min_o + 4'd1;
            default: nxt_digit = 4'd0;
        endcase
    end

    // Output decode: strobes, hour fix-up on leaving E_HT, and next-state views
    always_comb begin
        set_n    = 4'b0000;
        val_n    = 4'd0;
        run_en_n = (state_n == RUN);
        sel_n    = 4'b0000;
        if (mode_edge) begin
            if ((state == E_HT) && (hr_t == 4'd2) && (hr_o > 4'd3)) begin
                set_n = 4'b0100;
                val_n = 4'd0;
            end
        end else if (adv_evt) begin
            val_n = nxt_digit;
            case (state)
                E_HT:    set_n = 4'b1000;
                E_HO:    set_n = 4'b0100;
                E_MT:    set_n = 4'b0010;
                default: set_n = 4'b0001;
            endcase
        end
        case (state_n)
            E_HT:    sel_n = 4'b1000;
            E_HO:    sel_n = 4'b0100;
            E_MT:    sel_n = 4'b0010;
            E_MO:    sel_n = 4'b0001;
            default: sel_n = 4'b0000;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_val   <= 4'd0;
            set_hr_t  <= 1'b0;
            set_hr_o  <= 1'b0;
            set_min_t <= 1'b0;
            set_min_o <= 1'b0;
            run_en    <= 1'b1;
            edit_sel  <= 4'b0000;
        end else begin
            new_val   <= val_n;
            set_hr_t  <= set_n[3];
            set_hr_o  <= set_n[2];
            set_min_t <= set_n[1];
            set_min_o <= set_n[0];
            run_en    <= run_en_n;
            edit_sel  <= sel_n;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: cycle model plus directed scenarios.
module tb_time_set_ctrl;

    localparam int D  = 8;
    localparam int R  = 4;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_adv = 1'b0;
    logic [3:0] hr_t = 4'd0;
    logic [3:0] hr_o = 4'd0;
    logic [3:0] min_t = 4'd0;
    logic [3:0] min_o = 4'd0;
    logic [3:0] new_val;
    logic       set_hr_t;
    logic       set_hr_o;
    logic       set_min_t;
    logic       set_min_o;
    logic       run_en;
    logic [3:0] edit_sel;

    time_set_ctrl #(
        .REPEAT_DELAY(16'(D)),
        .REPEAT_RATE (16'(R)),
        .IDLE_TIMEOUT(24'(TO))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_adv  (btn_adv),
        .hr_t     (hr_t),
        .hr_o     (hr_o),
        .min_t    (min_t),
        .min_o    (min_o),
        .new_val  (new_val),
        .set_hr_t (set_hr_t),
        .set_hr_o (set_hr_o),
        .set_min_t(set_min_t),
        .set_min_o(set_min_o),
        .run_en   (run_en),
        .edit_sel (edit_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Model state: edit index (0 = RUN, 1..4 = hr_t..min_o), cycles ADV held,
    // cycles since last activity, and raw button sample history.
    int         m_st;
    int         m_hold;
    int         m_idle;
    logic [2:0] mh;
    logic [2:0] ah;
    logic [3:0] exp_strb;
    logic [3:0] exp_nv;
    logic [3:0] exp_sel;
    logic       exp_run;

    // Observed strobe log (environment side)
    int         cnt_ht, cnt_ho, cnt_mt, cnt_mo;
    logic [3:0] last_ht, last_ho, last_mt, last_mo;

    logic [3:0] walk_sel [5];
    int         total_c;
    int         c_ho;
    int         c_mt;
    int         c_mo;
    int         waited;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input int st);
        int v;
        int lim;
        case (st)
            1:       begin v = 32'(hr_t);  lim = 2; end
            2:       begin v = 32'(hr_o);  lim = (32'(hr_t) >= 2) ? 3 : 9; end
            3:       begin v = 32'(min_t); lim = 5; end
            default: begin v = 32'(min_o); lim = 9; end
        endcase
        return (v >= lim) ? 4'd0 : 4'(v + 1);
    endfunction

    function automatic logic [3:0] onehot(input int st);
        return (st == 0) ? 4'd0 : 4'(8 >> (st - 1));
    endfunction

    task automatic model_reset();
        m_st = 0; m_hold = 0; m_idle = 0;
        mh = 3'b000; ah = 3'b000;
        exp_strb = 4'd0; exp_nv = 4'd0; exp_sel = 4'd0; exp_run = 1'b1;
    endtask

    // One clock of the behavioural model, using the inputs seen at the last edge
    task automatic model_update();
        bit me, ae, al, edit, tick;
        int nst;
        me   = mh[1] && !mh[2];
        ae   = ah[1] && !ah[2];
        al   = ah[1];
        edit = (m_st != 0);
        tick = edit && al && ((m_hold == D) || ((m_hold > D) && ((m_hold - D) % R == 0)));
        nst = m_st;
        exp_strb = 4'd0;
        exp_nv = 4'd0;
        if (me) begin
            nst = (m_st + 1) % 5;
            if (m_st == 1 && 32'(hr_t) == 2 && 32'(hr_o) > 3) exp_strb = 4'b0100;
        end else if (edit && (ae || tick)) begin
            exp_strb = onehot(m_st);
            exp_nv = model_next(m_st);
        end else if (edit && m_idle == TO - 1) begin
            nst = 0;
        end
        m_idle = (!edit || me || ae || tick) ? 0 : m_idle + 1;
        m_hold = (nst != m_st || !al || !edit) ? 0 : m_hold + 1;
        m_st = nst;
        exp_run = (nst == 0);
        exp_sel = onehot(nst);
        mh = {mh[1:0], btn_mode};
        ah = {ah[1:0], btn_adv};
    endtask

    // Advance one cycle: model, compare, then let the digit registers load
    task automatic step();
        @(negedge clk);
        if (reset) begin
            model_reset();
        end else begin
            model_update();
            check("strobes", 32'({set_hr_t, set_hr_o, set_min_t, set_min_o}), 32'(exp_strb));
            check("run_en", 32'(run_en), 32'(exp_run));
            check("edit_sel", 32'(edit_sel), 32'(exp_sel));
            if (exp_strb != 4'd0) check("new_val", 32'(new_val), 32'(exp_nv));
        end
        if (set_hr_t)  begin cnt_ht++; last_ht = new_val; hr_t  = new_val; end
        if (set_hr_o)  begin cnt_ho++; last_ho = new_val; hr_o  = new_val; end
        if (set_min_t) begin cnt_mt++; last_mt = new_val; min_t = new_val; end
        if (set_min_o) begin cnt_mo++; last_mo = new_val; min_o = new_val; end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; step(); step();
        btn_mode = 1'b0; step(); step();
    endtask

    task automatic press_adv();
        btn_adv = 1'b1; step(); step();
        btn_adv = 1'b0; step(); step();
    endtask

    function automatic int total_strobes();
        return cnt_ht + cnt_ho + cnt_mt + cnt_mo;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        walk_sel = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
        cnt_ht = 0; cnt_ho = 0; cnt_mt = 0; cnt_mo = 0;
        last_ht = 4'd0; last_ho = 4'd0; last_mt = 4'd0; last_mo = 4'd0;
        model_reset();
        step(); step(); step();
        reset = 1'b0;
        step();

        phase = "reset";
        check("run_en", 32'(run_en), 1);
        check("edit_sel", 32'(edit_sel), 0);
        check("strobes", 32'({set_hr_t, set_hr_o, set_min_t, set_min_o}), 0);
        check("new_val", 32'(new_val), 0);

        phase = "mode_walk";
        for (int i = 0; i < 5; i++) begin
            press_mode();
            check("edit_sel", 32'(edit_sel), 32'(walk_sel[i]));
            check("run_en", 32'(run_en), (i == 4) ? 1 : 0);
        end
        check("no_strobes", 32'(total_strobes()), 0);

        phase = "mt_wrap";
        min_t = 4'd5;
        press_mode(); press_mode(); press_mode();
        check("edit_sel", 32'(edit_sel), 32'(4'b0010));
        total_c = total_strobes();
        btn_adv = 1'b1;
        step(); step();
        check("early", 32'(set_min_t), 0);
        step();
        check("set_min_t", 32'(set_min_t), 1);
        check("new_val", 32'(new_val), 0);
        btn_adv = 1'b0;
        step();
        check("one_cycle", 32'(set_min_t), 0);
        step(); step();
        check("count", 32'(total_strobes() - total_c), 1);
        check("min_t", 32'(min_t), 0);

        phase = "hours";
        press_mode(); press_mode();
        hr_t = 4'd1; hr_o = 4'd7;
        press_mode();
        check("edit_sel", 32'(edit_sel), 32'(4'b1000));
        press_adv();
        check("hr_t_val", 32'(last_ht), 2);
        check("hr_t_reg", 32'(hr_t), 2);
        c_ho = cnt_ho;
        press_mode();
        check("fixup_count", 32'(cnt_ho - c_ho), 1);
        check("fixup_val", 32'(last_ho), 0);
        check("edit_sel_ho", 32'(edit_sel), 32'(4'b0100));
        hr_o = 4'd3;
        press_adv();
        check("ho_wrap_count", 32'(cnt_ho - c_ho), 2);
        check("ho_wrap_val", 32'(hr_o), 0);

        phase = "repeat";
        press_mode(); press_mode();
        check("edit_sel", 32'(edit_sel), 32'(4'b0001));
        min_o = 4'd0;
        c_mo = cnt_mo;
        btn_adv = 1'b1;
        repeat (30) step();
        btn_adv = 1'b0;
        repeat (12) step();
        check("strobe_count", 32'(cnt_mo - c_mo), 7);
        check("min_o", 32'(min_o), 7);

        phase = "idle";
        waited = 0;
        while (!run_en && waited < 40) begin
            step();
            waited++;
        end
        check("back_to_run", 32'(run_en), 1);
        press_mode(); press_mode();
        check("edit_sel", 32'(edit_sel), 32'(4'b0100));
        total_c = total_strobes();
        repeat (18) step();
        check("still_editing", 32'(run_en), 0);
        step();
        check("timeout_run_en", 32'(run_en), 1);
        check("timeout_sel", 32'(edit_sel), 0);
        check("no_strobe", 32'(total_strobes() - total_c), 0);

        phase = "mode_adv";
        press_mode(); press_mode();
        c_ho = cnt_ho;
        c_mt = cnt_mt;
        btn_mode = 1'b1; btn_adv = 1'b1;
        step(); step();
        btn_mode = 1'b0; btn_adv = 1'b0;
        step(); step();
        check("edit_sel", 32'(edit_sel), 32'(4'b0010));
        check("no_set_hr_o", 32'(cnt_ho - c_ho), 0);
        check("no_set_min_t", 32'(cnt_mt - c_mt), 0);

        phase = "reset_mid_edit";
        c_mt = cnt_mt;
        btn_adv = 1'b1;
        repeat (15) step();
        check("repeat_ran", 32'(cnt_mt - c_mt), 3);
        #2 reset = 1'b1;
        #1;
        check("run_en", 32'(run_en), 1);
        check("edit_sel", 32'(edit_sel), 0);
        check("strobes", 32'({set_hr_t, set_hr_o, set_min_t, set_min_o}), 0);
        check("new_val", 32'(new_val), 0);
        step(); step(); step();
        reset = 1'b0;
        total_c = total_strobes();
        repeat (15) step();
        check("quiet", 32'(total_strobes() - total_c), 0);
        check("run_en_after", 32'(run_en), 1);
        check("edit_sel_after", 32'(edit_sel), 0);
        btn_adv = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
